pipeline_stall_controller: RTL and testbench
============================================

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-002 SHALL have parameter WAIT_MAX, default 15, maximum number of memory-wait cycles before timeout.
REQ-003 clk  in  1  single rising-edge clock.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 hdu_out  in  1  load-use hazard request from the ID-stage hazard detector.
REQ-006 branch_taken  in  1  branch resolved taken in EX.
REQ-007 jump  in  1  jump decoded in ID.
REQ-008 dmem_req  in  1  MEM-stage data-memory access active.
REQ-009 dmem_ready  in  1  data memory completes the access this cycle.
REQ-010 halt  in  1  halt instruction reached WB.
REQ-011 pc_write, ifid_write, idex_write, exmem_write  out  1 each  stage-register write enables.
REQ-012 ifid_flush, idex_flush, memwb_flush  out  1 each  insert a bubble (zero controls) into that register.
REQ-013 stall_count, flush_count  out  CNT_W each  statistics counters.
REQ-014 mem_timeout  out  1  sticky memory-timeout error.
REQ-015 halted  out  1  controller is in HALTED.

Function
REQ-016 SHALL implement FSM states RUN, MEM_WAIT, HALTED, with state registered and control outputs decoded combinationally from state and inputs in the same cycle (zero-latency stall).
REQ-017 Default (RUN, no event): all write enables 1, all flushes 0.
REQ-018 Priority in RUN, highest first: halt, memory wait, branch_taken, hdu_out, jump.
REQ-019 halt=1 in RUN: all write enables 0; next state HALTED.
REQ-020 dmem_req=1, dmem_ready=0 in RUN: all write enables 0, memwb_flush=1; next state MEM_WAIT; wait counter loads 1.
REQ-021 branch_taken=1: pc_write=1, ifid_flush=1, idex_flush=1; flush_count increments by 1.
REQ-022 hdu_out=1 without branch_taken: pc_write=0, ifid_write=0, idex_flush=1, exmem_write=1; stall_count increments by 1.
REQ-023 jump=1 with no higher event: ifid_flush=1 only; flush_count increments by 1.
REQ-024 MEM_WAIT, dmem_ready=0: outputs as REQ-020; wait counter increments; stall_count increments.
REQ-025 MEM_WAIT, dmem_ready=1: outputs evaluated exactly as RUN with the memory condition cleared (REQ-018 minus memory wait); next state RUN.
REQ-026 MEM_WAIT with wait counter equal to WAIT_MAX and dmem_ready=0: mem_timeout set; next state HALTED.
REQ-027 HALTED: all write enables 0, all flushes 0, halted=1; exits only through reset.
REQ-028 Counters SHALL saturate at all-ones and never wrap.
REQ-029 mem_timeout SHALL remain 1 until reset.
REQ-030 All inputs SHALL be ignored in HALTED; halt in MEM_WAIT is ignored until the access completes.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force state RUN, stall_count=0, flush_count=0, wait counter=0, mem_timeout=0, halted=0, regardless of current state.
REQ-032 While rst_n=0, write enables SHALL be 1 and flushes 0 (pipeline free-runs into its own reset).

Structure
REQ-033 FSM state encodings and the default WAIT_MAX/CNT_W values SHALL live in the shared pipeline package.
REQ-034 A single sub-module sat_counter (parameterised width, enable, synchronous active-low clear) SHALL implement both statistics counters.

Verification
REQ-035 Reset then hdu_out=1 one cycle -> pc_write=0, ifid_write=0, idex_flush=1 that cycle; stall_count=1 next cycle.
REQ-036 hdu_out=1 and branch_taken=1 together -> pc_write=1, ifid_flush=1, idex_flush=1; flush_count+1, stall_count unchanged.
REQ-037 dmem_req=1, dmem_ready low 3 cycles then high -> all writes 0 for 3 cycles, state MEM_WAIT, normal enables on ready cycle, RUN next, stall_count=3.
REQ-038 WAIT_MAX=4, dmem_ready held 0 -> mem_timeout=1 and halted=1 after cycle 4; remain set until rst_n=0.
REQ-039 CNT_W=4, hdu_out held 20 cycles -> stall_count saturates at 15.
REQ-040 rst_n=0 during MEM_WAIT -> RUN, counters 0 on next edge.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall controller: FSM states, event priority
// decode and the stage-control bundle.
package pipeline_stall_controller_pkg;

  localparam int DEFAULT_CNT_W    = 16;
  localparam int DEFAULT_WAIT_MAX = 15;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_HALT,
    EV_MEM,
    EV_BRANCH,
    EV_HAZARD,
    EV_JUMP
  } event_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                    exmem_write: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{default: 1'b0};

  // An unfinished memory access outranks halt, so a halt arriving during
  // MEM_WAIT is only honoured on the cycle the access completes.
  function automatic event_e decode_event(input state_e state, input logic halt,
                                          input logic dmem_req, input logic dmem_ready,
                                          input logic branch_taken, input logic hdu_out,
                                          input logic jump);
    event_e ev;
    ev = EV_NONE;
    if (state == HALTED)                          ev = EV_NONE;
    else if (state == MEM_WAIT && !dmem_ready)    ev = EV_MEM;
    else if (halt)                                ev = EV_HALT;
    else if (dmem_req && !dmem_ready)             ev = EV_MEM;
    else if (branch_taken)                        ev = EV_BRANCH;
    else if (hdu_out)                             ev = EV_HAZARD;
    else if (jump)                                ev = EV_JUMP;
    return ev;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!clr_n)
      count <= '0;
    else if (en && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard/stall controller: zero-latency stage enables and flushes
// from a RUN / MEM_WAIT / HALTED FSM, with stall and flush statistics.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CNT_W    = DEFAULT_CNT_W,
  parameter int WAIT_MAX = DEFAULT_WAIT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hdu_out,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout,
  output logic             halted
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  state_e            state, next_state;
  event_e            evt;
  ctrl_t             ctrl;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_timeout_q;
  logic              stall_en, flush_en;
  logic              wait_load, wait_inc, timeout_set;

  assign evt = decode_event(state, halt, dmem_req, dmem_ready, branch_taken, hdu_out, jump);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= next_state;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    next_state  = state;
    wait_load   = 1'b0;
    wait_inc    = 1'b0;
    timeout_set = 1'b0;
    case (state)
      RUN: begin
        if (evt == EV_HALT) next_state = HALTED;
        else if (evt == EV_MEM) begin
          next_state = MEM_WAIT;
          wait_load  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (evt == EV_MEM) begin
          if (wait_cnt == WAIT_W'(WAIT_MAX)) begin
            timeout_set = 1'b1;
            next_state  = HALTED;
          end else begin
            wait_inc = 1'b1;
          end
        end else if (evt == EV_HALT) begin
          next_state = HALTED;
        end else begin
          next_state = RUN;
        end
      end
      default: next_state = HALTED;
    endcase
  end

  // While reset is held the pipeline free-runs so it flushes into its own reset.
  always_comb begin
    ctrl     = CTRL_RUN;
    stall_en = 1'b0;
    flush_en = 1'b0;
    if (rst_n) begin
      if (state == HALTED) begin
        ctrl = CTRL_FREEZE;
      end else begin
        case (evt)
          EV_HALT: ctrl = CTRL_FREEZE;
          EV_MEM: begin
            ctrl             = CTRL_FREEZE;
            ctrl.memwb_flush = 1'b1;
            stall_en         = 1'b1;
          end
          EV_BRANCH: begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            flush_en        = 1'b1;
          end
          EV_HAZARD: begin
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
            ctrl.idex_flush = 1'b1;
            stall_en        = 1'b1;
          end
          EV_JUMP: begin
            ctrl.ifid_flush = 1'b1;
            flush_en        = 1'b1;
          end
          default: ctrl = CTRL_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt      <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      if (wait_load)     wait_cnt <= WAIT_W'(1);
      else if (wait_inc) wait_cnt <= wait_cnt + 1'b1;
      if (timeout_set)   mem_timeout_q <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (stall_en),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (flush_en),
    .count (flush_count)
  );

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign idex_write  = ctrl.idex_write;
  assign exmem_write = ctrl.exmem_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign memwb_flush = ctrl.memwb_flush;
  assign mem_timeout = mem_timeout_q;
  assign halted      = (state == HALTED);

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: a default-parameter instance (a) and a CNT_W=4/WAIT_MAX=4
// instance (b) share stimulus; control vector is {pc,ifid,idex,exmem,ifid_f,idex_f,memwb_f}.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, hdu_out, branch_taken, jump, dmem_req, dmem_ready, halt;

  logic pcw_a, ifw_a, idw_a, exw_a, iff_a, idf_a, mwf_a, tmo_a, hlt_a;
  logic pcw_b, ifw_b, idw_b, exw_b, iff_b, idf_b, mwf_b, tmo_b, hlt_b;
  logic [15:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;
  logic [6:0]  ctrl_a, ctrl_b;

  assign ctrl_a = {pcw_a, ifw_a, idw_a, exw_a, iff_a, idf_a, mwf_a};
  assign ctrl_b = {pcw_b, ifw_b, idw_b, exw_b, iff_b, idf_b, mwf_b};

  pipeline_stall_controller dut_a (
    .clk(clk), .rst_n(rst_n), .hdu_out(hdu_out), .branch_taken(branch_taken),
    .jump(jump), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt(halt),
    .pc_write(pcw_a), .ifid_write(ifw_a), .idex_write(idw_a), .exmem_write(exw_a),
    .ifid_flush(iff_a), .idex_flush(idf_a), .memwb_flush(mwf_a),
    .stall_count(stall_a), .flush_count(flush_a), .mem_timeout(tmo_a), .halted(hlt_a)
  );

  pipeline_stall_controller #(.CNT_W(4), .WAIT_MAX(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .hdu_out(hdu_out), .branch_taken(branch_taken),
    .jump(jump), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt(halt),
    .pc_write(pcw_b), .ifid_write(ifw_b), .idex_write(idw_b), .exmem_write(exw_b),
    .ifid_flush(iff_b), .idex_flush(idf_b), .memwb_flush(mwf_b),
    .stall_count(stall_b), .flush_count(flush_b), .mem_timeout(tmo_b), .halted(hlt_b)
  );

  localparam logic [6:0] C_RUN    = 7'b1111000;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_MEM    = 7'b0000001;
  localparam logic [6:0] C_HAZARD = 7'b0011010;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_JUMP   = 7'b1111100;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge and let combinational outputs settle.
  task automatic drive(input logic r, input logic h, input logic b, input logic j,
                       input logic rq, input logic rd, input logic hl);
    @(negedge clk);
    rst_n = r; hdu_out = h; branch_taken = b; jump = j;
    dmem_req = rq; dmem_ready = rd; halt = hl;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hdu_out = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0; halt = 1'b0;

    // Reset: pipeline free-runs while rst_n is low
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 1, 0, 1);
    check("rst_ctrl_free_run", ctrl_a, C_RUN);
    check("rst_stall_zero", stall_a, 0);
    check("rst_flush_zero", flush_a, 0);
    check("rst_timeout_zero", tmo_a, 0);
    check("rst_halted_zero", hlt_a, 0);

    // Load-use hazard
    drive(1, 1, 0, 0, 0, 0, 0);
    check("hazard_ctrl", ctrl_a, C_HAZARD);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("idle_ctrl", ctrl_a, C_RUN);
    check("hazard_stall_cnt", stall_a, 1);

    // Branch outranks hazard
    drive(1, 1, 1, 0, 0, 0, 0);
    check("branch_over_hazard_ctrl", ctrl_a, C_BRANCH);
    drive(1, 0, 0, 1, 0, 0, 0);
    check("jump_ctrl", ctrl_a, C_JUMP);
    check("branch_flush_cnt", flush_a, 1);
    check("branch_stall_unchanged", stall_a, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("jump_flush_cnt", flush_a, 2);

    // Memory wait three cycles, halt ignored while waiting, then ready
    drive(1, 0, 0, 0, 1, 0, 0);
    check("memwait_c1_ctrl", ctrl_a, C_MEM);
    drive(1, 1, 1, 0, 1, 0, 0);
    check("memwait_c2_ctrl", ctrl_a, C_MEM);
    drive(1, 0, 0, 0, 1, 0, 1);
    check("memwait_halt_ignored", ctrl_a, C_MEM);
    drive(1, 0, 0, 0, 1, 1, 0);
    check("memwait_ready_ctrl", ctrl_a, C_RUN);
    drive(1, 0, 0, 0, 1, 1, 0);
    check("run_after_ready_ctrl", ctrl_a, C_RUN);
    check("memwait_stall_cnt", stall_a, 4);
    check("memwait_not_halted", hlt_a, 0);

    // Branch resolved on the ready cycle of a wait
    drive(1, 0, 0, 0, 1, 0, 0);
    drive(1, 1, 1, 0, 1, 1, 0);
    check("ready_branch_ctrl", ctrl_a, C_BRANCH);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("ready_branch_flush_cnt", flush_a, 3);
    check("ready_branch_stall_cnt", stall_a, 5);

    // Reset in the middle of MEM_WAIT
    drive(1, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    check("rst_in_wait_ctrl", ctrl_a, C_RUN);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("after_wait_rst_ctrl", ctrl_a, C_RUN);
    check("after_wait_rst_stall", stall_a, 0);
    check("after_wait_rst_flush", flush_a, 0);

    // Timeout on instance b (WAIT_MAX=4): five stall cycles, then HALTED
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 0, 0, 1, 0, 0);
      check($sformatf("tmo_wait_c%0d_ctrl_b", i), ctrl_b, C_MEM);
      check($sformatf("tmo_wait_c%0d_flag_b", i), tmo_b, 0);
    end
    drive(1, 0, 0, 0, 1, 0, 0);
    check("tmo_set_b", tmo_b, 1);
    check("tmo_halted_b", hlt_b, 1);
    check("tmo_freeze_b", ctrl_b, C_FREEZE);
    check("tmo_stall_cnt_b", stall_b, 5);
    check("tmo_default_still_waiting", ctrl_a, C_MEM);
    check("tmo_default_no_flag", tmo_a, 0);
    drive(1, 1, 1, 0, 1, 1, 0);
    check("halted_ignores_inputs_b", ctrl_b, C_FREEZE);
    check("default_ready_branch_ctrl", ctrl_a, C_BRANCH);
    drive(1, 0, 0, 1, 0, 0, 0);
    check("tmo_sticky_b", tmo_b, 1);
    check("halted_sticky_b", hlt_b, 1);
    check("halted_stall_frozen_b", stall_b, 5);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rst_from_halted_ctrl_b", ctrl_b, C_RUN);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("tmo_cleared_b", tmo_b, 0);
    check("halted_cleared_b", hlt_b, 0);
    check("stall_cleared_b", stall_b, 0);

    // Saturation: 20 hazard cycles
    for (int i = 0; i < 20; i++) drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("stall_saturated_b", stall_b, 15);
    check("stall_count_a", stall_a, 20);

    // Halt outranks everything in RUN
    drive(1, 1, 1, 1, 1, 0, 1);
    check("halt_ctrl", ctrl_a, C_FREEZE);
    drive(1, 1, 0, 1, 0, 0, 0);
    check("halt_halted", hlt_a, 1);
    check("halted_ctrl", ctrl_a, C_FREEZE);
    check("halt_stall_unchanged", stall_a, 20);
    drive(1, 0, 1, 0, 0, 0, 0);
    check("halted_flush_unchanged", flush_a, 0);
    check("halted_no_timeout", tmo_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
